// File: rtl/reg_file_pkg.sv
// Shared widths, zero-register constant and data/address types for the register file.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through forwarding on the read ports).
package reg_file_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned DEPTH_DEFAULT  = 2 ** ADDR_W_DEFAULT;
  localparam int unsigned ZERO_REG       = 0;

  typedef logic [DATA_W_DEFAULT-1:0] data_t;
  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

  // True when an address targets a writable register.
  function automatic logic is_writable(input addr_t addr);
    return addr != addr_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address mux, zero-register check and optional forwarding.
// Forwarding of the in-flight write is compiled in only when REG_FILE_BYPASS_EN is defined.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            ra,
`ifdef REG_FILE_BYPASS_EN
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wa,
  input  logic [DATA_W-1:0]            wd,
`endif
  output logic [DATA_W-1:0]            rd
);

  logic ra_is_zero;

  assign ra_is_zero = (ra == ADDR_W'(ZERO_REG));

`ifdef REG_FILE_BYPASS_EN
  logic fwd_hit;

  // A write to register 0 is discarded, so it must never be forwarded either.
  assign fwd_hit = we && (wa != ADDR_W'(ZERO_REG)) && (wa == ra);

  always_comb begin
    rd = '0;
    if (ra_is_zero) begin
      rd = '0;
    end else if (fwd_hit) begin
      rd = wd;
    end else begin
      rd = regs[ra];
    end
  end
`else
  always_comb begin
    rd = '0;
    if (!ra_is_zero) begin
      rd = regs[ra];
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// Register file with two combinational read ports, one write port and a hardwired-zero r0.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // r0 has no storage; only registers 1..DEPTH-1 are flops.
  logic [DEPTH-1:1][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_view;
  logic [DEPTH-1:1]             wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_sel[i] = we3 && (wa3 == ADDR_W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= wd3;
        end
      end
    end
  end

  assign regs_view = {regs_q, {DATA_W{1'b0}}};

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_read_port1 (
    .regs (regs_view),
    .ra   (ra1),
`ifdef REG_FILE_BYPASS_EN
    .we   (we3),
    .wa   (wa3),
    .wd   (wd3),
`endif
    .rd   (rd1)
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_read_port2 (
    .regs (regs_view),
    .ra   (ra2),
`ifdef REG_FILE_BYPASS_EN
    .we   (we3),
    .wa   (wa3),
    .wd   (wd3),
`endif
    .rd   (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, writes, r0, hold, same-cycle read/write.
// Expected values follow REG_FILE_BYPASS_EN when the bench is built with that macro.
module tb_reg_file;

  logic        clock;
  logic        reset_n;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int n_checks;
  int n_fail;

  reg_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .we3     (we3),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa3     (wa3),
    .wd3     (wd3),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge, away from the sampling point.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    @(posedge clock);
    #1;
    we3 = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return (32'(i) << 24) | 32'h005A_5A00 | 32'(i);
  endfunction

  logic [31:0] exp_pre;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    we3      = 1'b0;
    ra1      = '0;
    ra2      = '0;
    wa3      = '0;
    wd3      = '0;

    #2 reset_n = 1'b0;
    #1;
    ra1 = 5'd5;
    ra2 = 5'd31;
    #1;
    check_eq("in_reset_rd1", rd1, 32'h0);
    check_eq("in_reset_rd2", rd2, 32'h0);

    // Write attempted while reset is held must be blocked.
    @(posedge clock);
    #1;
    wr(5'd4, 32'h1111_2222);
    ra1 = 5'd4;
    #1;
    check_eq("write_blocked_in_reset", rd1, 32'h0);

    reset_n = 1'b1;
    ra1 = 5'd5;
    ra2 = 5'd31;
    #1;
    check_eq("post_reset_rd1", rd1, 32'h0);
    check_eq("post_reset_rd2", rd2, 32'h0);

    // Write r3 and read through both ports.
    wr(5'd3, 32'hDEAD_BEEF);
    ra1 = 5'd3;
    ra2 = 5'd3;
    #1;
    check_eq("r3_rd1", rd1, 32'hDEAD_BEEF);
    check_eq("r3_rd2", rd2, 32'hDEAD_BEEF);

    // Writes to r0 are ignored, including any forwarding.
    we3 = 1'b1;
    wa3 = 5'd0;
    wd3 = 32'hFFFF_FFFF;
    ra1 = 5'd0;
    #1;
    check_eq("r0_during_write", rd1, 32'h0);
    @(posedge clock);
    #1;
    we3 = 1'b0;
    #1;
    check_eq("r0_after_write", rd1, 32'h0);

    // we3=0 must hold r7.
    wr(5'd7, 32'h0000_000A);
    we3 = 1'b0;
    wa3 = 5'd7;
    wd3 = 32'h1234_5678;
    @(posedge clock);
    #1;
    ra2 = 5'd7;
    #1;
    check_eq("r7_hold", rd2, 32'h0000_000A);

    // Same-cycle read/write of r9.
    wr(5'd9, 32'h0000_0001);
    ra1 = 5'd9;
    ra2 = 5'd7;
    we3 = 1'b1;
    wa3 = 5'd9;
    wd3 = 32'hCAFE_F00D;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 32'hCAFE_F00D;
`else
    exp_pre = 32'h0000_0001;
`endif
    check_eq("r9_before_edge", rd1, exp_pre);
    check_eq("r7_unaffected_by_r9_write", rd2, 32'h0000_000A);
    @(posedge clock);
    #1;
    we3 = 1'b0;
    wd3 = 32'h0;
    #1;
    check_eq("r9_after_edge", rd1, 32'hCAFE_F00D);

    // Fill r1..r31 and read back on alternating ports.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), pat(i));
    end
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(32 - i);
      #1;
      check_eq($sformatf("fill_rd1_r%0d", i), rd1, pat(i));
      check_eq($sformatf("fill_rd2_r%0d", 32 - i), rd2, pat(32 - i));
    end

    // Asynchronous reset pulse between edges clears everything immediately.
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #0.1;
      check_eq($sformatf("async_clr_rd1_r%0d", i), rd1, 32'h0);
      check_eq($sformatf("async_clr_rd2_r%0d", 31 - i), rd2, 32'h0);
    end

    // Reset held across a write edge wins; target reads 0.
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    we3 = 1'b1;
    wa3 = 5'd12;
    wd3 = 32'h7777_8888;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    we3 = 1'b0;
    reset_n = 1'b1;
    ra1 = 5'd12;
    #1;
    check_eq("reset_wins_r12", rd1, 32'h0);

    // Writes resume on the first edge after release.
    wr(5'd12, 32'h0000_0055);
    #1;
    check_eq("write_resumes_r12", rd1, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001: Parameter DATA_W, default 32, SHALL set the register and data width in bits.
REQ-002: Parameter ADDR_W, default 5, SHALL set the address width; depth is 2**ADDR_W (32) registers.
REQ-003: clock  input  1  SHALL be the single clock; all writes occur on its rising edge.
REQ-004: reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: we3  input  1  SHALL be the write enable for port 3.
REQ-006: ra1  input  ADDR_W  SHALL be the read address for port 1.
REQ-007: ra2  input  ADDR_W  SHALL be the read address for port 2.
REQ-008: wa3  input  ADDR_W  SHALL be the write address for port 3.
REQ-009: wd3  input  DATA_W  SHALL be the write data for port 3.
REQ-010: rd1  output  DATA_W  SHALL be the read data for port 1.
REQ-011: rd2  output  DATA_W  SHALL be the read data for port 2.

Function
REQ-012: Storage SHALL be 2**ADDR_W registers of DATA_W bits each, with two read ports and one write port.
REQ-013: On a rising edge of clock with we3=1 and wa3!=0, register[wa3] SHALL load wd3.
REQ-014: When we3=0, no register SHALL change.
REQ-015: Register 0 SHALL be hardwired to zero; writes to address 0 SHALL be ignored.
REQ-016: rd1 SHALL be combinational from ra1, with zero clock latency; rd1 = 0 when ra1 = 0.
REQ-017: rd2 SHALL be combinational from ra2, with zero clock latency; rd2 = 0 when ra2 = 0.
REQ-018: A value written on a given edge SHALL be visible on rd1/rd2 immediately after that edge; before the edge, reads SHALL return the old value (unless REG_FILE_BYPASS_EN is defined).
REQ-019: ra1 == ra2 SHALL return identical data on both ports.
REQ-020: All writes SHALL use the full DATA_W width; there are no partial writes.

Reset
REQ-021: Assertion of reset_n=0 SHALL asynchronously clear all registers to 0, so that rd1 = rd2 = 0 for any address.
REQ-022: While reset_n=0, writes SHALL be blocked.
REQ-023: Writes SHALL resume on the first rising edge after reset_n deasserts.
REQ-024: Reset asserted mid-write SHALL win; the target register reads 0.

Configuration
REQ-025: The macro REG_FILE_BYPASS_EN, when defined, SHALL enable write-through forwarding: if we3=1 and wa3!=0 and raN==wa3, then rdN = wd3 combinationally, in the same cycle.
REQ-026: Without REG_FILE_BYPASS_EN, reads SHALL return only stored register contents.
REQ-027: Address-0 reads SHALL return 0 regardless of the macro.

Structure
REQ-028: Package reg_file_pkg SHALL hold DATA_W/ADDR_W defaults, the constant ZERO_REG = 0, and the data/address typedefs.
REQ-029: One sub-module, reg_file_read_port, SHALL be used: it implements the address mux, the zero-register check and the optional bypass, and is instantiated twice (ports 1 and 2).

Verification
REQ-030: Reset with reset_n=0, then release; read ra1=5, ra2=31 -> rd1=00000000, rd2=00000000.
REQ-031: we3=1, wa3=3, wd3=DEADBEEF at an edge; next cycle ra1=3, ra2=3 -> rd1=rd2=DEADBEEF.
REQ-032: we3=1, wa3=0, wd3=FFFFFFFF; then ra1=0 -> rd1=00000000.
REQ-033: we3=0, wa3=7, wd3=12345678 after register 7 holds 0000000A -> ra2=7 reads 0000000A.
REQ-034: Same-cycle read/write of wa3=ra1=9 with wd3=CAFEF00D, register 9 holding 00000001 -> rd1=00000001 before the edge (CAFEF00D with REG_FILE_BYPASS_EN); CAFEF00D after the edge in both builds.
REQ-035: reset_n pulsed low asynchronously between edges after registers 1-31 are written -> all reads return 00000000 immediately.
